// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the register file write port between NUM_REQ
// writeback sources, with a registered issue stage, forwarding flags and a commit counter.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         WriteReg,
    output logic [DATA_W-1:0]         WriteData,
    output logic                      RegWrite,
    input  logic [ADDR_W-1:0]         Read1,
    input  logic [ADDR_W-1:0]         Read2,
    output logic                      fwd1_hit,
    output logic                      fwd2_hit,
    output logic [DATA_W-1:0]         fwd_data,
    output logic [15:0]               wr_count
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] LAST_IDX = (PTR_W+1)'(NUM_REQ - 1);

    logic [PTR_W-1:0]   ptr_r;
    logic               regwrite_r;
    logic [ADDR_W-1:0]  writereg_r;
    logic [DATA_W-1:0]  writedata_r;
    logic [15:0]        wr_count_r;

    logic [PTR_W:0]     sum_s;
    logic               found_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic               xfer_s;
    logic [PTR_W-1:0]   next_ptr_s;

    // Round-robin search starting at ptr_r, wrapping modulo NUM_REQ
    always_comb begin
        sum_s       = '0;
        found_s     = 1'b0;
        grant_idx_s = '0;
        grant_s     = '0;
        sel_addr_s  = '0;
        sel_data_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_s = {1'b0, ptr_r} + (PTR_W+1)'(k);
            if (sum_s > LAST_IDX) begin
                sum_s = sum_s - LAST_IDX - (PTR_W+1)'(1);
            end else begin
                sum_s = sum_s;
            end
            if (!found_s && req_valid[sum_s[PTR_W-1:0]]) begin
                found_s                     = 1'b1;
                grant_idx_s                 = sum_s[PTR_W-1:0];
                grant_s[sum_s[PTR_W-1:0]]   = 1'b1;
                sel_addr_s = req_addr[sum_s[PTR_W-1:0]*ADDR_W +: ADDR_W];
                sel_data_s = req_data[sum_s[PTR_W-1:0]*DATA_W +: DATA_W];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant gating during reset, transfer detect and next pointer
    always_comb begin
        if (reset_n) begin
            req_ready = grant_s;
            xfer_s    = found_s;
        end else begin
            req_ready = '0;
            xfer_s    = 1'b0;
        end
        if (grant_idx_s == LAST_IDX[PTR_W-1:0]) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_idx_s + PTR_W'(1);
        end
    end

    // Issue stage, round-robin pointer and committed-write counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r       <= '0;
            regwrite_r  <= 1'b0;
            writereg_r  <= '0;
            writedata_r <= '0;
            wr_count_r  <= 16'd0;
        end else begin
            if (regwrite_r) begin
                wr_count_r <= wr_count_r + 16'd1;
            end else begin
                wr_count_r <= wr_count_r;
            end
            if (xfer_s) begin
                ptr_r <= next_ptr_s;
                // register 0 is hard-wired to zero: complete the handshake, skip the write
                if (sel_addr_s != '0) begin
                    regwrite_r  <= 1'b1;
                    writereg_r  <= sel_addr_s;
                    writedata_r <= sel_data_s;
                end else begin
                    regwrite_r  <= 1'b0;
                end
            end else begin
                regwrite_r <= 1'b0;
            end
        end
    end

    assign RegWrite  = regwrite_r;
    assign WriteReg  = writereg_r;
    assign WriteData = writedata_r;
    assign wr_count  = wr_count_r;
    assign fwd_data  = writedata_r;
    assign fwd1_hit  = regwrite_r & (Read1 == writereg_r);
    assign fwd2_hit  = regwrite_r & (Read2 == writereg_r);

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 16-bit, 32-entry register file between NUM_REQ independent writeback sources (ALU result, memory load, link/stack unit).
- Uses round-robin arbitration with a valid/ready handshake, then a registered issue stage that drives WriteReg/WriteData/RegWrite into the register file.
- Provides same-cycle forwarding flags for the two read ports, covering the window in which a write is issued but not yet committed.
- Keeps a committed-write counter for debug.

Parameters:
- NUM_REQ, 3, number of write requesters (2..8).
- ADDR_W, 5, register address width.
- DATA_W, 16, register data width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  bit i = requester i has a write pending.
- req_addr  in  NUM_REQ*ADDR_W  requester i destination register, in slice [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  requester i write data, in slice [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
- WriteReg  out  ADDR_W  register file write address.
- WriteData  out  DATA_W  register file write data.
- RegWrite  out  1  register file write enable.
- Read1  in  ADDR_W  register file read address 1, snooped.
- Read2  in  ADDR_W  register file read address 2, snooped.
- fwd1_hit  out  1  the in-flight write targets Read1.
- fwd2_hit  out  1  the in-flight write targets Read2.
- fwd_data  out  DATA_W  equals WriteData.
- wr_count  out  16  number of committed writes, wrapping.

Behaviour:
- Reset (reset_n low, asynchronous):
  - RegWrite=0, WriteReg=0, WriteData=0, wr_count=0.
  - Round-robin pointer ptr=0.
  - req_ready is forced to all zeros for as long as reset_n is low.
  - A write that is in flight when reset asserts is discarded; the register file sees no write.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, incrementing and wrapping modulo NUM_REQ.
  - The first set bit g gets req_ready[g]=1; all other ready bits are 0.
  - If no req_valid bit is set, req_ready=0.
  - req_ready may depend combinationally on req_valid.
  - Requesters hold valid, addr and data stable until their transfer occurs.
- Pointer update:
  - On a transfer from requester g, ptr <= (g+1) mod NUM_REQ.
  - With no transfer, ptr holds.
  - A requester that keeps valid high is granted at least once every NUM_REQ cycles; there is no starvation.
- Issue stage, on each rising edge:
  - Transfer with addr!=0: RegWrite<=1, WriteReg<=addr, WriteData<=data.
  - Transfer with addr==0: the handshake completes normally, but RegWrite<=0 because register 0 is hard-wired to zero. WriteReg and WriteData hold their previous values.
  - No transfer: RegWrite<=0; WriteReg and WriteData hold their previous values.
  - Throughput is one write per cycle; back-to-back transfers keep RegWrite high on consecutive cycles.
- Latency:
  - Transfer at edge N gives RegWrite high during cycle N..N+1.
  - The register file commits at edge N+1, so the new value is readable after edge N+1.
- Forwarding (combinational):
  - fwd1_hit = RegWrite & (Read1==WriteReg). fwd2_hit is the same with Read2.
  - WriteReg is never 0 while RegWrite is high, so register 0 never forwards.
  - Downstream muxes select fwd_data when a hit flag is high.
- wr_count:
  - Increments by 1 at every rising edge where RegWrite is high.
  - Wraps 0xFFFF -> 0x0000.
  - Accepts to register 0 are not counted.
- Simultaneous requests: exactly one grant per cycle. The losers keep valid high and are served in round-robin order on later cycles.

Test Plan:
- Single write: hold reset_n low, release, then pulse req_valid[0] with addr=4, data=0x0002 -> req_ready[0]=1 that cycle; next cycle RegWrite=1, WriteReg=4, WriteData=0x0002; wr_count=1.
- Fairness: all three requesters valid continuously (addrs 1/2/3, data 0x11/0x22/0x33) -> grants 0,1,2,0,1,2; WriteReg sequence 1,2,3,1,2,3; RegWrite high every cycle.
- Register 0: requester 1 writes addr=0, data=3 -> req_ready[1]=1, RegWrite stays 0, wr_count unchanged.
- Forwarding: write addr=6, data=5 with Read1=6 and Read2=4 -> fwd1_hit=1, fwd2_hit=0, fwd_data=0x0005 during the RegWrite cycle; both flags 0 the cycle after.
- Async reset mid-operation: drop reset_n between edges while RegWrite=1 -> RegWrite, wr_count and req_ready go to 0 immediately without waiting for a clock edge; after release, the first grant goes to the lowest valid index.
- Counter wrap: force 65536 committed writes -> wr_count returns to 0x0000.
